// File: rtl/alu_pkg.sv
// Shared ALU definitions: subtract-unit FSM encodings and flag bit positions
// used by both the flag producer and the compare logic.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_W = 3;

endpackage

// File: rtl/chunk_sub.sv
// One CHUNK-bit slice of A + ~B + cin; combinational.
// Also exposes the carry into the slice MSB so the top can derive signed overflow.
module chunk_sub #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] nb,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] full;

    assign full = {1'b0, a} + {1'b0, nb} + {{CHUNK{1'b0}}, cin};
    assign sum  = full[CHUNK-1:0];
    assign cout = full[CHUNK];
    // Carry into the top bit recovered from its sum bit.
    assign cmsb = a[CHUNK-1] ^ nb[CHUNK-1] ^ sum[CHUNK-1];

endmodule

// File: rtl/sub_flag_unit.sv
// Iterative A - B, one CHUNK slice per cycle LSB first, producing Z/V/N flags.
// Latency N cycles accept-to-valid; result held in DONE until out_ready, flush aborts.
module sub_flag_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Zero,
    output logic             Overflow,
    output logic             Negative
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t              state, state_nxt;
    logic [CW-1:0]       cnt;
    logic [WIDTH-1:0]    a_q, nb_q, diff_q;
    logic                signed_q, carry, zero_acc;
    logic [FLAG_W-1:0]   flags_q;
    logic [CHUNK-1:0]    a_sl, nb_sl, sum;
    logic                cout, cmsb, accept;

    assign a_sl  = a_q[int'(cnt) * CHUNK +: CHUNK];
    assign nb_sl = nb_q[int'(cnt) * CHUNK +: CHUNK];

    chunk_sub #(.CHUNK(CHUNK)) u_slice (
        .a    (a_sl),
        .nb   (nb_sl),
        .cin  (carry),
        .sum  (sum),
        .cout (cout),
        .cmsb (cmsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        accept    = (state == IDLE) && in_valid && !flush;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (in_valid)      state_nxt = RUN;
                RUN:     if (cnt == LAST)   state_nxt = DONE;
                DONE:    if (out_ready)     state_nxt = IDLE;
                default:                    state_nxt = IDLE;
            endcase
        end
    end

    // Flush freezes the datapath; the stale result is simply never presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            nb_q     <= '0;
            diff_q   <= '0;
            signed_q <= 1'b0;
            carry    <= 1'b0;
            zero_acc <= 1'b0;
            cnt      <= '0;
            flags_q  <= '0;
        end else if (!flush) begin
            if (accept) begin
                a_q      <= A;
                nb_q     <= ~B;
                signed_q <= Signed;
                carry    <= 1'b1;
                cnt      <= '0;
                zero_acc <= 1'b1;
            end else if (state == RUN) begin
                diff_q[int'(cnt) * CHUNK +: CHUNK] <= sum;
                carry    <= cout;
                zero_acc <= zero_acc & (sum == '0);
                cnt      <= cnt + CW'(1);
                if (cnt == LAST) begin
                    flags_q[FLAG_Z] <= zero_acc & (sum == '0);
                    flags_q[FLAG_V] <= signed_q & (cmsb ^ cout);
                    flags_q[FLAG_N] <= signed_q ? sum[CHUNK-1] : ~cout;
                end
            end
        end
    end

    assign Diff     = diff_q;
    assign Zero     = flags_q[FLAG_Z];
    assign Overflow = flags_q[FLAG_V];
    assign Negative = flags_q[FLAG_N];

endmodule

// File: tb/tb_sub_flag_unit.sv
// Scoreboard bench for sub_flag_unit: expectations queued at accept, compared at output handshake.
module tb_sub_flag_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        Signed = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] Diff;
    logic        Zero, Overflow, Negative;

    typedef struct {
        logic [31:0] diff;
        logic        z, v, n, lt;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   hs_count = 0;

    always #5 clk = ~clk;

    sub_flag_unit #(.WIDTH(32), .CHUNK(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Signed    (Signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
        .Zero      (Zero),
        .Overflow  (Overflow),
        .Negative  (Negative)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t e;
        e.diff = a - b;
        e.z    = (e.diff == 32'd0);
        e.v    = s && (a[31] != b[31]) && (e.diff[31] != a[31]);
        e.n    = s ? e.diff[31] : (a < b);
        e.lt   = s ? ($signed(a) < $signed(b)) : (a < b);
        return e;
    endfunction

    // Output side of the scoreboard: every handshake pops one expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !flush) begin
            hs_count++;
            if (sb.size() == 0) begin
                check("sb_unexpected_output", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("diff", Diff, e.diff);
                check("zero", Zero, e.z);
                check("ovf",  Overflow, e.v);
                check("neg",  Negative, e.n);
                check("lt",   Negative ^ Overflow, e.lt);
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_send", in_ready, 1);
        A = a; B = b; Signed = s; in_valid = 1'b1;
        sb.push_back(model(a, b, s));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Scramble operands: they must have been captured at the accept edge.
        A = $urandom; B = $urandom; Signed = ~s;
    endtask

    // Called just after the accept edge; waits for out_valid, holds, then releases.
    task automatic collect(input int hold);
        int   lat;
        int   h0;
        logic [34:0] snap;
        lat = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            lat = n + 1;
            if (out_valid) break;
        end
        if (!out_valid) begin
            check("out_valid_timeout", out_valid, 1);
            return;
        end
        check("latency", lat, 4);
        snap = {Diff, Zero, Overflow, Negative};
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_stable", {Diff, Zero, Overflow, Negative}, snap);
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        h0 = hs_count;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("one_handshake", hs_count, h0 + 1);
        check("idle_valid", out_valid, 0);
        check("idle_in_ready", in_ready, 1);
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_outputs", {Diff, Zero, Overflow, Negative}, 35'd0);
        #20;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Equal operands, signed
        send(32'd5, 32'd5, 1'b1);                   collect(0);
        // Signed overflow both directions
        send(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1);   collect(0);
        send(32'h8000_0000, 32'd1, 1'b1);           collect(0);
        // Unsigned borrow and inter-slice carry
        send(32'd1, 32'd2, 1'b0);                   collect(0);
        send(32'h0000_0100, 32'd1, 1'b0);           collect(0);
        // Backpressure with a competing request while DONE
        send(32'h1234_5678, 32'h0000_FFFF, 1'b0);
        fork
            collect(3);
            begin
                repeat (5) @(posedge clk);
                #2;
                in_valid = 1'b1;
                #1;
                check("done_blocks_input", in_ready, 0);
                in_valid = 1'b0;
            end
        join
        check("no_stray_accept", {30'd0, dut.state}, 32'd0);

        // Flush in second RUN cycle
        send(32'hDEAD_BEEF, 32'h1, 1'b1);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        void'(sb.pop_back());
        check("flush_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("flush_never_valid", out_valid, 0);
        end
        out_ready = 1'b0;
        send(32'd10, 32'd3, 1'b0);                  collect(0);

        // flush beats in_valid in IDLE
        @(posedge clk);
        #1;
        flush = 1'b1; in_valid = 1'b1; A = 32'd9; B = 32'd1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_no_accept", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("flush_idle_quiet", out_valid, 0);
        end

        // Async reset mid-RUN
        send(32'hFFFF_0000, 32'h0000_1111, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        check("arst_valid", out_valid, 0);
        check("arst_outputs", {Diff, Zero, Overflow, Negative}, 35'd0);
        check("arst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("post_arst_in_ready", in_ready, 1);
        send(32'd0, 32'd0, 1'b0);                   collect(0);

        // Random mix
        for (int i = 0; i < 20; i++) begin
            send($urandom, $urandom, 1'($urandom_range(0, 1)));
            collect(i % 3);
        end

        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
